// File: rtl/add_subtract_unit.sv
// rtl/add_subtract_unit.sv - 32-bit two-level carry-lookahead add/sub with registered status (optional ADD_SUBTRACT_OVF_EN)
module add_subtract_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] result_o,
    output logic        cout_o,
    output logic [31:0] result_q_o,
    output logic        cout_q_o,
    output logic        zero_q_o,
    output logic        neg_q_o,
    output logic        ovf_q_o
);

    logic [31:0] b_x;
    logic [31:0] bit_g;
    logic [31:0] bit_p;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [8:0]  grp_c;
    logic [31:0] bit_c;
    logic [31:0] sum;
    logic        c32;

    // Subtract is A + ~B + 1; the +1 enters as the carry-in of group 0.
    assign b_x   = b_i ^ {32{cin_i}};
    assign bit_g = a_i & b_x;
    assign bit_p = a_i ^ b_x;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            grp_g[k] = bit_g[4*k+3]
                     | (bit_p[4*k+3] & bit_g[4*k+2])
                     | (bit_p[4*k+3] & bit_p[4*k+2] & bit_g[4*k+1])
                     | (bit_p[4*k+3] & bit_p[4*k+2] & bit_p[4*k+1] & bit_g[4*k]);
            grp_p[k] = &bit_p[4*k +: 4];
        end
    end

    // Second level: every group carry is a flat sum of products of the group terms.
    always_comb begin
        logic term;
        logic prop;
        grp_c    = '0;
        grp_c[0] = cin_i;
        for (int k = 0; k < 8; k++) begin
            term = grp_g[k];
            prop = grp_p[k];
            for (int j = k - 1; j >= 0; j--) begin
                term = term | (prop & grp_g[j]);
                prop = prop & grp_p[j];
            end
            grp_c[k+1] = term | (prop & cin_i);
        end
    end

    always_comb begin
        logic term;
        logic prop;
        bit_c = '0;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                term = 1'b0;
                prop = 1'b1;
                for (int j = i - 1; j >= 0; j--) begin
                    term = term | (prop & bit_g[4*k+j]);
                    prop = prop & bit_p[4*k+j];
                end
                bit_c[4*k+i] = term | (prop & grp_c[k]);
            end
        end
    end

    assign sum      = bit_p ^ bit_c;
    assign c32      = grp_c[8];
    assign result_o = sum;
    assign cout_o   = c32 ^ cin_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_q_o <= '0;
            cout_q_o   <= 1'b0;
            zero_q_o   <= 1'b0;
            neg_q_o    <= 1'b0;
        end else begin
            result_q_o <= sum;
            cout_q_o   <= c32 ^ cin_i;
            zero_q_o   <= (sum == 32'd0);
            neg_q_o    <= sum[31];
        end
    end

`ifdef ADD_SUBTRACT_OVF_EN
    logic ovf;

    // Using the inverted B covers both modes: operands of equal sign whose sum flips sign.
    assign ovf = (a_i[31] == b_x[31]) && (sum[31] != a_i[31]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q_o <= 1'b0;
        end else begin
            ovf_q_o <= ovf;
        end
    end
`else
    assign ovf_q_o = 1'b0;
`endif

endmodule

// File: tb/tb_add_subtract_unit.sv
// tb/tb_add_subtract_unit.sv - self-checking bench for add_subtract_unit
module tb_add_subtract_unit;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        cin_i;
    logic [31:0] result_o;
    logic        cout_o;
    logic [31:0] result_q_o;
    logic        cout_q_o;
    logic        zero_q_o;
    logic        neg_q_o;
    logic        ovf_q_o;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef ADD_SUBTRACT_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    add_subtract_unit dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .cin_i      (cin_i),
        .result_o   (result_o),
        .cout_o     (cout_o),
        .result_q_o (result_q_o),
        .cout_q_o   (cout_q_o),
        .zero_q_o   (zero_q_o),
        .neg_q_o    (neg_q_o),
        .ovf_q_o    (ovf_q_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] r;
        logic        co;
        logic        ov;
    } vec_t;

    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b, input logic sub);
        return sub ? (a - b) : (a + b);
    endfunction

    function automatic logic ref_cout(input logic [31:0] a, input logic [31:0] b, input logic sub);
        longint unsigned wide;
        if (sub) return (a < b);
        wide = longint'(a) + longint'(b);
        return (wide > 64'hFFFF_FFFF);
    endfunction

    function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b, input logic sub);
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = sub ? (sa - sb) : (sa + sb);
        return OVF_EN && ((r > 64'sd2147483647) || (r < -64'sd2147483648));
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin);
        @(negedge clk_i);
        a_i   = a;
        b_i   = b;
        cin_i = cin;
        #1;
    endtask

    task automatic test_reset;
        tests_run++;
        if ({result_q_o, cout_q_o, zero_q_o, neg_q_o, ovf_q_o} !== 36'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got q=%h co=%b z=%b n=%b v=%b, want all 0",
                     result_q_o, cout_q_o, zero_q_o, neg_q_o, ovf_q_o);
        end
        tests_run++;
        if (result_o !== 32'h0000_0005) begin
            tests_failed++;
            $display("FAIL reset_comb: got %h want 00000005", result_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_directed;
        vec_t v[$];
        logic exp_ov;
        v.push_back('{32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0});
        v.push_back('{32'h0000_3039, 32'h0000_1A85, 1'b0, 32'h0000_4ABE, 1'b0, 1'b0});
        v.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
        v.push_back('{32'h0000_000A, 32'h0000_0009, 1'b1, 32'h0000_0001, 1'b0, 1'b0});
        v.push_back('{32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b0, 1'b0});
        v.push_back('{32'h0002_F145, 32'h000F_1206, 1'b1, 32'hFFF3_DF3F, 1'b1, 1'b0});
        v.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
        v.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1});
        v.push_back('{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0});
        v.push_back('{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b0, 1'b0});
        foreach (v[i]) begin
            drive(v[i].a, v[i].b, v[i].cin);
            tests_run++;
            if ({result_o, cout_o} !== {v[i].r, v[i].co}) begin
                tests_failed++;
                $display("FAIL directed_comb[%0d]: got r=%h co=%b want r=%h co=%b",
                         i, result_o, cout_o, v[i].r, v[i].co);
            end
            @(posedge clk_i);
            #1;
            exp_ov = OVF_EN & v[i].ov;
            tests_run++;
            if ({result_q_o, cout_q_o, zero_q_o, neg_q_o, ovf_q_o} !==
                {v[i].r, v[i].co, (v[i].r == 32'd0), v[i].r[31], exp_ov}) begin
                tests_failed++;
                $display("FAIL directed_reg[%0d]: got q=%h co=%b z=%b n=%b v=%b want q=%h co=%b z=%b n=%b v=%b",
                         i, result_q_o, cout_q_o, zero_q_o, neg_q_o, ovf_q_o,
                         v[i].r, v[i].co, (v[i].r == 32'd0), v[i].r[31], exp_ov);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] er;
        for (int n = 0; n < 300; n++) begin
            a   = $urandom;
            b   = $urandom;
            sub = 1'($urandom_range(0, 1));
            if (n % 10 == 0) b = a;
            if (n % 10 == 1) b = ~a;
            if (n % 10 == 2) a = {a[31], 31'h7FFF_FFFF};
            er = ref_result(a, b, sub);
            drive(a, b, sub);
            tests_run++;
            if ({result_o, cout_o} !== {er, ref_cout(a, b, sub)}) begin
                tests_failed++;
                $display("FAIL random_comb: a=%h b=%h sub=%b got r=%h co=%b want r=%h co=%b",
                         a, b, sub, result_o, cout_o, er, ref_cout(a, b, sub));
            end
            @(posedge clk_i);
            #1;
            tests_run++;
            if ({result_q_o, cout_q_o, zero_q_o, neg_q_o, ovf_q_o} !==
                {er, ref_cout(a, b, sub), (er == 32'd0), er[31], ref_ovf(a, b, sub)}) begin
                tests_failed++;
                $display("FAIL random_reg: a=%h b=%h sub=%b got q=%h co=%b z=%b n=%b v=%b want q=%h co=%b z=%b n=%b v=%b",
                         a, b, sub, result_q_o, cout_q_o, zero_q_o, neg_q_o, ovf_q_o,
                         er, ref_cout(a, b, sub), (er == 32'd0), er[31], ref_ovf(a, b, sub));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] prev_r;
        logic [31:0] a;
        logic [31:0] b;
        prev_r = 32'd0;
        for (int n = 0; n < 20; n++) begin
            a = $urandom;
            b = $urandom;
            @(negedge clk_i);
            if (n > 0) begin
                tests_run++;
                if (result_q_o !== prev_r) begin
                    tests_failed++;
                    $display("FAIL back_to_back[%0d]: got q=%h want %h", n, result_q_o, prev_r);
                end
            end
            a_i    = a;
            b_i    = b;
            cin_i  = 1'b0;
            prev_r = a + b;
        end
    endtask

    task automatic test_mid_reset;
        drive(32'h0002_F145, 32'h000F_1206, 1'b1);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        tests_run++;
        if ({result_q_o, cout_q_o, zero_q_o, neg_q_o, ovf_q_o} !== 36'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_regs: got q=%h co=%b z=%b n=%b v=%b want all 0",
                     result_q_o, cout_q_o, zero_q_o, neg_q_o, ovf_q_o);
        end
        tests_run++;
        if ({result_o, cout_o} !== {32'hFFF3_DF3F, 1'b1}) begin
            tests_failed++;
            $display("FAIL mid_reset_comb: got r=%h co=%b want r=fff3df3f co=1", result_o, cout_o);
        end
        @(posedge clk_i);
        #1;
        tests_run++;
        if (result_q_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_held: got q=%h want 00000000", result_q_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        tests_run++;
        if ({result_q_o, cout_q_o, neg_q_o} !== {32'hFFF3_DF3F, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL first_capture: got q=%h co=%b n=%b want q=fff3df3f co=1 n=1",
                     result_q_o, cout_q_o, neg_q_o);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        a_i   = 32'd2;
        b_i   = 32'd3;
        cin_i = 1'b0;
        #1;
        @(posedge clk_i);
        #1;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/add_subtract_unit.md
# add_subtract_unit

32-bit combinational adder/subtractor with a registered status stage. `cin_i` selects the operation: 0 adds, 1 subtracts. In subtract mode `cout_o` reports an unsigned borrow. The block sits in the datapath as the integer add/sub unit. Downstream logic uses the combinational outputs in the same cycle, or the registered copies one clock later.

## Interface
- No parameters; the datapath width is fixed at 32 bits.
- `clk_i` — input, 1 — clock; all registers update on the rising edge.
- `rst_i` — input, 1 — asynchronous, active-high reset.
- `a_i` — input, 32 — operand A, the minuend in subtract mode.
- `b_i` — input, 32 — operand B, the subtrahend in subtract mode.
- `cin_i` — input, 1 — operation select: 0 = add (A+B), 1 = subtract (A−B).
- `result_o` — output, 32 — combinational sum or difference, modulo 2^32.
- `cout_o` — output, 1 — combinational carry (add) or borrow (subtract).
- `result_q_o` — output, 32 — `result_o` registered.
- `cout_q_o` — output, 1 — `cout_o` registered.
- `zero_q_o` — output, 1 — registered flag, 1 when `result_o` is 0.
- `neg_q_o` — output, 1 — registered copy of `result_o[31]`.
- `ovf_q_o` — output, 1 — registered signed overflow; present only per Configuration.

## Operation
- Internal sum: `{c32, s} = a_i + (b_i ^ {32{cin_i}}) + cin_i`.
  - Subtract is A + ~B + 1 (two's complement).
- `result_o = s[31:0]`.
- `cout_o = c32 ^ cin_i`:
  - Add mode: the true carry-out.
  - Subtract mode: borrow, which is 1 exactly when A < B as unsigned numbers.
- Adder structure:
  - Eight 4-bit carry-lookahead groups.
  - Group generate/propagate combined by a second-level lookahead across the groups.
  - A plain ripple chain is not acceptable.
- Signed overflow (before registering):
  - Add: `a[31]==b[31] && s[31]!=a[31]`.
  - Subtract: `a[31]!=b[31] && s[31]!=a[31]`.
- Boundary cases:
  - 0xFFFFFFFF + 1 → result 0, cout 1.
  - 0 − 1 → result 0xFFFFFFFF, cout 1.
  - A − A → result 0, cout 0.
  - 0x80000000 − 1 → result 0x7FFFFFFF, ovf 1.
- X/Z on inputs need not be handled specially.

## Timing
- `result_o` and `cout_o` are purely combinational with zero-cycle latency.
  - They are valid within the propagation delay after any input change.
  - They do not depend on `clk_i` or `rst_i`.
- Registered outputs have 1-cycle latency.
  - Each edge of `clk_i` captures the current combinational values.
  - There is no enable and no handshake; capture happens every cycle.
- Reset:
  - While `rst_i` is high, all registered outputs are 0, asynchronously, regardless of the clock.
  - The first capture happens on the first rising edge after `rst_i` falls.
- Reset asserted mid-operation clears the registered outputs immediately. The combinational outputs keep tracking the inputs.

## Configuration
- Macro: `ADD_SUBTRACT_OVF_EN`.
- Defined:
  - The overflow logic and its register are compiled in.
  - `ovf_q_o` reports signed overflow with 1-cycle latency and resets to 0.
- Undefined:
  - The overflow logic and its register are omitted.
  - `ovf_q_o` is tied to constant 0; the port list is unchanged.

## Test plan
- Add, small and mid-range operands:
  - a=0x00000001, b=0x00000001, cin=0 → result 0x00000002, cout 0.
  - a=0x00003039, b=0x00001A85, cin=0 → result 0x00004ABE, cout 0.
- Add wrap-around: a=0xFFFFFFFF, b=0x00000001, cin=0 → result 0x00000000, cout 1. After the next clock edge: `zero_q_o`=1, `cout_q_o`=1.
- Subtract without borrow:
  - a=0x0000000A, b=0x00000009, cin=1 → result 0x00000001, cout 0.
  - a=0x00000001, b=0x00000001, cin=1 → result 0x00000000, cout 0.
- Subtract with borrow: a=0x0002F145, b=0x000F1206, cin=1 → result 0xFFF3DF3F, cout 1. After the next clock edge: `neg_q_o`=1.
- Signed overflow:
  - With `ADD_SUBTRACT_OVF_EN` defined:
    - a=0x7FFFFFFF, b=1, cin=0 → `ovf_q_o`=1 one cycle later.
    - a=0x80000000, b=1, cin=1 → `ovf_q_o`=1 one cycle later.
  - Without the macro: `ovf_q_o` stays 0 for both.
- Reset: assert `rst_i` between clock edges with registers holding nonzero values → all `*_q_o` go to 0 immediately, while `result_o` still reflects the inputs.
